// File: rtl/snake_link_pkg.sv
// ---------------------------------------------------------------------------
// snake_link_pkg
// Shared definitions for the board-to-board snake link (TX scheduler and RX
// parser): transmit FSM state encoding, frame header constants and the frame
// checksum helper.
// ---------------------------------------------------------------------------
package snake_link_pkg;

    // Transmit FSM states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HEADER   = 2'd1,
        ST_PAYLOAD  = 2'd2,
        ST_CHECKSUM = 2'd3
    } link_state_e;

    // Header byte is LINK_HDR_BASE | id; id LINK_HB_ID marks a heartbeat
    localparam logic [7:0] LINK_HDR_BASE = 8'hA0;
    localparam logic [3:0] LINK_HB_ID    = 4'hF;

    // Largest payload the checksum helper accepts (bytes)
    localparam int LINK_MAX_PAYLOAD_BYTES = 16;

    // Build a header byte from a 4-bit id
    function automatic logic [7:0] link_header(input logic [3:0] id);
        return LINK_HDR_BASE | {4'h0, id};
    endfunction

    // XOR of the header and every payload byte. Payloads shorter than the
    // maximum are zero-extended by the caller; zero bytes leave XOR unchanged.
    function automatic logic [7:0] link_checksum(
        input logic [7:0]                            hdr,
        input logic [8*LINK_MAX_PAYLOAD_BYTES-1:0]   payload
    );
        logic [7:0] acc;
        acc = hdr;
        for (int i = 0; i < LINK_MAX_PAYLOAD_BYTES; i++) begin
            acc = acc ^ payload[8*i +: 8];
        end
        return acc;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. The search starts at index `ptr` and
// wraps modulo NUM_REQ; the first set request found wins.
// Ports:
//   req    in  NUM_REQ  request vector
//   enable in  1        arbitration allowed this cycle
//   ptr    in  PTR_W    highest-priority index (must be < NUM_REQ)
//   grant  out NUM_REQ  one-hot winner (all zero when valid=0)
//   valid  out 1        a winner exists
// ---------------------------------------------------------------------------
module rr_arbiter
    import snake_link_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic               valid
);

    logic [PTR_W:0] scan_idx;

    // Rotating priority scan starting at ptr
    always_comb begin
        grant    = '0;
        valid    = 1'b0;
        scan_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = {1'b0, ptr} + (PTR_W+1)'(i);
            if (scan_idx >= (PTR_W+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (PTR_W+1)'(NUM_REQ);
            end else begin
                scan_idx = scan_idx;
            end
            if (enable && !valid && req[scan_idx[PTR_W-1:0]]) begin
                grant[scan_idx[PTR_W-1:0]] = 1'b1;
                valid                      = 1'b1;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/link_tx_scheduler.sv
// ---------------------------------------------------------------------------
// link_tx_scheduler
// Shares the UART TX byte path between NUM_REQ requesters. Arbitrates
// round-robin, latches the winner's payload, and streams the frame
// header (A0|id), FRAME_BYTES payload bytes, XOR checksum over a
// valid/ready handshake. Optional heartbeat frames (header AF, zero payload)
// are sent after HEARTBEAT_CYCLES idle cycles when SNAKE_LINK_HEARTBEAT_EN
// is defined; otherwise the heartbeat logic is absent.
// Ports:
//   clk        in  1                       system clock
//   rst_n      in  1                       synchronous active-low reset
//   req        in  NUM_REQ                 level requests, held until grant
//   frame_data in  NUM_REQ*FRAME_BYTES*8   payloads, slice i = requester i
//   grant      out NUM_REQ                 one-hot pulse when payload latched
//   tx_data    out 8                       byte to UART TX
//   tx_valid   out 1                       tx_data valid
//   tx_ready   in  1                       UART TX accepts byte
//   busy       out 1                       FSM not in IDLE
// ---------------------------------------------------------------------------
module link_tx_scheduler
    import snake_link_pkg::*;
#(
    parameter int NUM_REQ          = 3,
    parameter int FRAME_BYTES      = 4,
    parameter int HEARTBEAT_CYCLES = 750_000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ*FRAME_BYTES*8-1:0] frame_data,
    output logic [NUM_REQ-1:0]               grant,
    output logic [7:0]                       tx_data,
    output logic                             tx_valid,
    input  logic                             tx_ready,
    output logic                             busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int PAY_W = FRAME_BYTES * 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BYTES - 1);

    link_state_e                state_q, state_d;
    logic [PTR_W-1:0]           ptr_q, ptr_d;
    logic [PAY_W-1:0]           shadow_q, shadow_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [7:0]                 csum_q, csum_d;
    logic [7:0]                 tx_data_q, tx_data_d;

    logic [NUM_REQ-1:0]         arb_grant_s;
    logic                       arb_valid_s;
    logic                       arb_enable_s;
    logic [PTR_W-1:0]           win_idx_s;
    logic [PTR_W-1:0]           ptr_next_s;
    logic [PAY_W-1:0]           win_payload_s;
    logic [CNT_W-1:0]           cnt_inc_s;
    logic [7:0]                 hdr_s;
    logic [8*LINK_MAX_PAYLOAD_BYTES-1:0] pad_s;
    logic                       hb_due_s;
    logic                       frame_done_s;

    // Grant is suppressed while reset is asserted so it reads zero in reset
    assign arb_enable_s = (state_q == ST_IDLE) && rst_n;
    assign frame_done_s = (state_q == ST_CHECKSUM) && tx_ready;
    assign cnt_inc_s    = cnt_q + CNT_W'(1);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req    (req),
        .enable (arb_enable_s),
        .ptr    (ptr_q),
        .grant  (arb_grant_s),
        .valid  (arb_valid_s)
    );

    // One-hot grant to index, next pointer and winner payload slice
    always_comb begin
        win_idx_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant_s[i]) begin
                win_idx_s = PTR_W'(i);
            end else begin
                win_idx_s = win_idx_s;
            end
        end
        if (win_idx_s == PTR_W'(NUM_REQ - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = win_idx_s + PTR_W'(1);
        end
        win_payload_s = frame_data[int'(win_idx_s) * PAY_W +: PAY_W];
    end

`ifdef SNAKE_LINK_HEARTBEAT_EN
    localparam int HB_W = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
    localparam logic [HB_W-1:0] HB_TERM = HB_W'(HEARTBEAT_CYCLES - 1);

    logic [HB_W-1:0] hb_cnt_q, hb_cnt_d;

    assign hb_due_s = (hb_cnt_q == HB_TERM);

    // Idle counter: counts IDLE cycles, saturates at terminal, clears on frame end
    always_comb begin
        if (frame_done_s) begin
            hb_cnt_d = '0;
        end else if ((state_q == ST_IDLE) && !hb_due_s) begin
            hb_cnt_d = hb_cnt_q + HB_W'(1);
        end else begin
            hb_cnt_d = hb_cnt_q;
        end
    end

    // Heartbeat counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hb_cnt_q <= '0;
        end else begin
            hb_cnt_q <= hb_cnt_d;
        end
    end
`else
    assign hb_due_s = 1'b0;
`endif

    // Frame FSM next-state and datapath
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        shadow_d  = shadow_q;
        cnt_d     = cnt_q;
        csum_d    = csum_q;
        tx_data_d = tx_data_q;
        hdr_s     = 8'h00;
        pad_s     = '0;
        case (state_q)
            ST_IDLE: begin
                // Requests take priority over a due heartbeat
                if (arb_valid_s) begin
                    hdr_s                = link_header(4'(win_idx_s));
                    pad_s[PAY_W-1:0]     = win_payload_s;
                    shadow_d             = win_payload_s;
                    csum_d               = link_checksum(hdr_s, pad_s);
                    tx_data_d            = hdr_s;
                    ptr_d                = ptr_next_s;
                    cnt_d                = '0;
                    state_d              = ST_HEADER;
                end else if (hb_due_s) begin
                    hdr_s     = link_header(LINK_HB_ID);
                    shadow_d  = '0;
                    csum_d    = link_checksum(hdr_s, pad_s);
                    tx_data_d = hdr_s;
                    cnt_d     = '0;
                    state_d   = ST_HEADER;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HEADER: begin
                if (tx_ready) begin
                    tx_data_d = shadow_q[7:0];
                    state_d   = ST_PAYLOAD;
                end else begin
                    state_d = ST_HEADER;
                end
            end
            ST_PAYLOAD: begin
                if (tx_ready) begin
                    if (cnt_q == CNT_LAST) begin
                        tx_data_d = csum_q;
                        state_d   = ST_CHECKSUM;
                    end else begin
                        cnt_d     = cnt_inc_s;
                        tx_data_d = shadow_q[8*int'(cnt_inc_s) +: 8];
                    end
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_CHECKSUM: begin
                if (tx_ready) begin
                    tx_data_d = 8'h00;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_CHECKSUM;
                end
            end
            default: begin
                tx_data_d = 8'h00;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // FSM and datapath registers; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            shadow_q  <= '0;
            cnt_q     <= '0;
            csum_q    <= 8'h00;
            tx_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            shadow_q  <= shadow_d;
            cnt_q     <= cnt_d;
            csum_q    <= csum_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign grant    = arb_grant_s;
    assign tx_data  = tx_data_q;
    assign tx_valid = (state_q != ST_IDLE);
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_link_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_link_tx_scheduler
// Randomised + directed bench. A transaction-level reference model decides
// each cycle which frame (if any) starts, pushes its bytes to a scoreboard
// queue, and a separate monitor pops and compares every accepted byte.
// Follows SNAKE_LINK_HEARTBEAT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_link_tx_scheduler;

    localparam int NR = 3;
    localparam int FB = 2;
    localparam int HB = 20;
`ifdef SNAKE_LINK_HEARTBEAT_EN
    localparam bit HB_EN = 1'b1;
`else
    localparam bit HB_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req;
    logic [NR*FB*8-1:0] frame_data;
    logic [NR-1:0]     grant;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] m_frame[$];
    int         m_ptr = 0;
    int         m_hb  = 0;

    always #5 clk = ~clk;

    link_tx_scheduler #(
        .NUM_REQ          (NR),
        .FRAME_BYTES      (FB),
        .HEARTBEAT_CYCLES (HB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .frame_data (frame_data),
        .grant      (grant),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one decision per cycle from the frame-level rules
    always @(negedge clk) begin
        int         w;
        int         c;
        logic [7:0] hdr;
        logic [7:0] b;
        logic [7:0] cs;
        logic [NR-1:0] exp_grant;
        if (!rst_n) begin
            m_ptr = 0;
            m_hb  = 0;
            m_frame.delete();
            exp_q.delete();
        end else begin
            check("busy", 64'(busy), 64'(m_frame.size() != 0));
            check("tx_valid", 64'(tx_valid), 64'(m_frame.size() != 0));
            exp_grant = '0;
            if (m_frame.size() == 0) begin
                w = -1;
                for (int i = 0; i < NR; i++) begin
                    c = (m_ptr + i) % NR;
                    if (w < 0 && req[c]) w = c;
                end
                if (w >= 0) begin
                    exp_grant = NR'(1) << w;
                    hdr = 8'hA0 | 8'(w);
                    cs  = hdr;
                    m_frame.push_back(hdr);
                    exp_q.push_back(hdr);
                    for (int k = 0; k < FB; k++) begin
                        b  = frame_data[(w*FB + k)*8 +: 8];
                        cs = cs ^ b;
                        m_frame.push_back(b);
                        exp_q.push_back(b);
                    end
                    m_frame.push_back(cs);
                    exp_q.push_back(cs);
                    m_ptr = (w + 1) % NR;
                end else if (HB_EN && m_hb == HB - 1) begin
                    m_frame.push_back(8'hAF);
                    exp_q.push_back(8'hAF);
                    for (int k = 0; k < FB; k++) begin
                        m_frame.push_back(8'h00);
                        exp_q.push_back(8'h00);
                    end
                    m_frame.push_back(8'hAF);
                    exp_q.push_back(8'hAF);
                end else if (m_hb < HB - 1) begin
                    m_hb++;
                end
            end else if (tx_ready) begin
                void'(m_frame.pop_front());
                if (m_frame.size() == 0) m_hb = 0;
            end
            check("grant", 64'(grant), 64'(exp_grant));
        end
    end

    // Monitor: compares accepted bytes and handshake stability
    always @(negedge clk) begin
        logic [7:0] prev_data;
        bit         prev_stall;
        logic [7:0] e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(tx_valid), 64'(1));
                check("hold_data", 64'(tx_data), 64'(prev_data));
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected no byte at %0t", tx_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", 64'(tx_data), 64'(e));
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for a grant pulse; returns just after the following edge
    task automatic wait_grant(output logic [NR-1:0] g);
        bit found;
        found = 1'b0;
        g     = '0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clk);
            if (grant != '0) begin
                found = 1'b1;
                g     = grant;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: no grant within 60 cycles, a grant was required");
        end
        tick();
    endtask

    initial begin
        logic [NR-1:0] g;
        logic [NR-1:0] rr_exp[4];
        bit drained;
        rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;

        rst_n = 1'b0; req = '0; frame_data = '0; tx_ready = 1'b1;
        repeat (2) tick();
        check("rst_tx_valid", 64'(tx_valid), 64'(0));
        check("rst_tx_data", 64'(tx_data), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_grant", 64'(grant), 64'(0));
        rst_n = 1'b1;

        // Collision: request lands on the cycle the heartbeat becomes due
        repeat (19) tick();
        frame_data = 48'({$urandom(), $urandom()});
        req = 3'b001;
        wait_grant(g);
        check("collision_grant", 64'(g), 64'(3'b001));
        req = '0;
        repeat (50) tick();

        // Single request, fixed payload
        frame_data = 48'({$urandom(), $urandom()});
        frame_data[31:16] = 16'h3412;
        req = 3'b010;
        wait_grant(g);
        check("single_grant", 64'(g), 64'(3'b010));
        req = '0;
        frame_data = 48'({$urandom(), $urandom()});
        check("single_hdr", 64'(tx_data), 64'(8'hA1));
        tick();
        check("single_b0", 64'(tx_data), 64'(8'h12));
        tick();
        check("single_b1", 64'(tx_data), 64'(8'h34));
        tick();
        check("single_csum", 64'(tx_data), 64'(8'h87));
        tick();
        check("single_idle", 64'(busy), 64'(0));

        // Round-robin from a fresh pointer
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 3'b111;
        for (int f = 0; f < 4; f++) begin
            wait_grant(g);
            check("rr_grant", 64'(g), 64'(rr_exp[f]));
        end
        req = '0;
        repeat (10) tick();

        // Backpressure during payload
        req = 3'b001;
        wait_grant(g);
        req = '0;
        tick();
        tx_ready = 1'b0;
        repeat (5) tick();
        tx_ready = 1'b1;
        repeat (10) tick();

        // Reset mid-frame, then requester 1 must win first
        req = 3'b001;
        wait_grant(g);
        req = '0;
        tick();
        rst_n = 1'b0;
        req = 3'b110;
        tick();
        check("midrst_valid", 64'(tx_valid), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        rst_n = 1'b1;
        wait_grant(g);
        check("midrst_first_grant", 64'(g), 64'(3'b010));
        req = '0;
        repeat (10) tick();

        // Randomised traffic with idle stretches and occasional resets
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ((cyc % 400) < 60) begin
                req = '0;
            end else begin
                for (int i = 0; i < NR; i++) req[i] = ($urandom_range(0, 9) < 3);
            end
            tx_ready   = ($urandom_range(0, 9) < 8);
            frame_data = 48'({$urandom(), $urandom()});
            rst_n      = ($urandom_range(0, 999) != 0);
            tick();
        end
        rst_n = 1'b1; req = '0; tx_ready = 1'b1;

        // Long quiet period: only heartbeats (if enabled) may appear
        repeat (120) tick();

        drained = 1'b0;
        for (int k = 0; k < 100 && !drained; k++) begin
            if (exp_q.size() == 0 && !busy) drained = 1'b1;
            else tick();
        end
        check("drain", 64'(drained), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
